// File: rtl/cpu_pkg.sv
// cpu_pkg: shared opcodes, ALU function codes and control state encoding.
package cpu_pkg;
  typedef enum logic [1:0] {S_FETCH, S_EXEC, S_MEM, S_WB} state_t;
  localparam int OP_LOADI = 'h00;
  localparam int OP_MOV   = 'h01;
  localparam int OP_ADD   = 'h02;
  localparam int OP_SUB   = 'h03;
  localparam int OP_AND   = 'h04;
  localparam int OP_OR    = 'h05;
  localparam int OP_J     = 'h06;
  localparam int OP_BEQ   = 'h07;
  localparam int OP_BNE   = 'h08;
  localparam int OP_SRL   = 'h09;
  localparam int OP_SLL   = 'h0A;
  localparam int OP_ROR   = 'h0B;
  localparam int OP_SRA   = 'h0C;
  localparam int OP_MUL   = 'h0D;
  localparam int OP_LWD   = 'h0E;
  localparam int OP_LWI   = 'h0F;
  localparam int OP_SWD   = 'h10;
  localparam int OP_SWI   = 'h11;
  localparam int ALU_FWD  = 0;
  localparam int ALU_ADD  = 1;
  localparam int ALU_AND  = 2;
  localparam int ALU_OR   = 3;
  localparam int ALU_SRL  = 4;
  localparam int ALU_SLL  = 5;
  localparam int ALU_ROR  = 6;
  localparam int ALU_SRA  = 7;
  localparam int ALU_MUL  = 8;
endpackage

// File: rtl/ctrl_decode.sv
// ctrl_decode: pure opcode to datapath-control decode used during EXEC.
module ctrl_decode
  import cpu_pkg::*;
#(
  parameter int OPCODE_W = 8,
  parameter int ALUOP_W  = 4
) (
  input  logic [OPCODE_W-1:0] opcode,
  output logic [ALUOP_W-1:0]  aluop,
  output logic                we,
  output logic                minus,
  output logic                imm,
  output logic                branch,
  output logic                jump,
  output logic                bne,
  output logic                is_mem,
  output logic                is_store,
  output logic                illegal
);
  always_comb begin
    aluop    = '0;
    we       = 1'b0;
    minus    = 1'b0;
    imm      = 1'b0;
    branch   = 1'b0;
    jump     = 1'b0;
    bne      = 1'b0;
    is_mem   = 1'b0;
    is_store = 1'b0;
    illegal  = 1'b0;
    case (opcode)
      OPCODE_W'(OP_LOADI): begin imm = 1'b1; we = 1'b1; end
      OPCODE_W'(OP_MOV):   we = 1'b1;
      OPCODE_W'(OP_ADD):   begin aluop = ALUOP_W'(ALU_ADD); we = 1'b1; end
      OPCODE_W'(OP_SUB):   begin aluop = ALUOP_W'(ALU_ADD); minus = 1'b1; we = 1'b1; end
      OPCODE_W'(OP_AND):   begin aluop = ALUOP_W'(ALU_AND); we = 1'b1; end
      OPCODE_W'(OP_OR):    begin aluop = ALUOP_W'(ALU_OR); we = 1'b1; end
      OPCODE_W'(OP_J):     jump = 1'b1;
      OPCODE_W'(OP_BEQ):   begin aluop = ALUOP_W'(ALU_ADD); minus = 1'b1; branch = 1'b1; end
      OPCODE_W'(OP_BNE):   begin aluop = ALUOP_W'(ALU_ADD); minus = 1'b1; bne = 1'b1; end
      OPCODE_W'(OP_SRL):   begin aluop = ALUOP_W'(ALU_SRL); imm = 1'b1; we = 1'b1; end
      OPCODE_W'(OP_SLL):   begin aluop = ALUOP_W'(ALU_SLL); imm = 1'b1; we = 1'b1; end
      OPCODE_W'(OP_ROR):   begin aluop = ALUOP_W'(ALU_ROR); imm = 1'b1; we = 1'b1; end
      OPCODE_W'(OP_SRA):   begin aluop = ALUOP_W'(ALU_SRA); imm = 1'b1; we = 1'b1; end
      OPCODE_W'(OP_MUL):   begin aluop = ALUOP_W'(ALU_MUL); we = 1'b1; end
      OPCODE_W'(OP_LWD):   is_mem = 1'b1;
      OPCODE_W'(OP_LWI):   begin is_mem = 1'b1; imm = 1'b1; end
      OPCODE_W'(OP_SWD):   begin is_mem = 1'b1; is_store = 1'b1; end
      OPCODE_W'(OP_SWI):   begin is_mem = 1'b1; is_store = 1'b1; imm = 1'b1; end
      default:             illegal = 1'b1;
    endcase
  end
endmodule

// File: rtl/control_fsm.sv
// control_fsm: FETCH/EXEC/MEM/WB sequencer with memory wait timeout and sticky error.
module control_fsm
  import cpu_pkg::*;
#(
  parameter int INSTR_W  = 32,
  parameter int OPCODE_W = 8,
  parameter int ALUOP_W  = 4,
  parameter int TIMEOUT  = 16
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic [INSTR_W-1:0] INSTRUCTION,
  input  logic               INSTR_VALID,
  input  logic               MEM_BUSYWAIT,
  output logic [ALUOP_W-1:0] ALUOP,
  output logic               WRITEENABLE,
  output logic               MUX_MINUS,
  output logic               MUX_IMMEDIATE,
  output logic               MUX_MEMDATA,
  output logic               BRANCH,
  output logic               JUMP,
  output logic               B_NOTEQUAL,
  output logic               MEM_READ,
  output logic               MEM_WRITE,
  output logic               PC_ADVANCE,
  output logic               ILLEGAL,
  output logic               MEM_ERR
);
  localparam int CW = $clog2(TIMEOUT + 1);
  state_t state_q, state_d;
  logic [OPCODE_W-1:0] op_q, op_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic mem_err_q, mem_err_d;
  logic [ALUOP_W-1:0] d_aluop;
  logic d_we, d_minus, d_imm, d_branch, d_jump, d_bne, d_mem, d_store, d_illegal;
  logic unused_instr;
  assign unused_instr = ^INSTRUCTION[INSTR_W-OPCODE_W-1:0];
  ctrl_decode #(.OPCODE_W(OPCODE_W), .ALUOP_W(ALUOP_W)) u_dec (
    .opcode(op_q), .aluop(d_aluop), .we(d_we), .minus(d_minus), .imm(d_imm),
    .branch(d_branch), .jump(d_jump), .bne(d_bne), .is_mem(d_mem),
    .is_store(d_store), .illegal(d_illegal)
  );
  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    cnt_d         = cnt_q;
    mem_err_d     = mem_err_q;
    ALUOP         = '0;
    WRITEENABLE   = 1'b0;
    MUX_MINUS     = 1'b0;
    MUX_IMMEDIATE = 1'b0;
    MUX_MEMDATA   = 1'b0;
    BRANCH        = 1'b0;
    JUMP          = 1'b0;
    B_NOTEQUAL    = 1'b0;
    MEM_READ      = 1'b0;
    MEM_WRITE     = 1'b0;
    PC_ADVANCE    = 1'b0;
    ILLEGAL       = 1'b0;
    case (state_q)
      S_FETCH: if (INSTR_VALID) begin
        op_d    = INSTRUCTION[INSTR_W-1 -: OPCODE_W];
        state_d = S_EXEC;
      end
      S_EXEC: begin
        ALUOP         = d_aluop;
        WRITEENABLE   = d_we;
        MUX_MINUS     = d_minus;
        MUX_IMMEDIATE = d_imm;
        BRANCH        = d_branch;
        JUMP          = d_jump;
        B_NOTEQUAL    = d_bne;
        ILLEGAL       = d_illegal;
        PC_ADVANCE    = !d_mem;
        cnt_d         = '0;
        state_d       = d_mem ? S_MEM : S_FETCH;
      end
      // Timeout abandons the access: retire without writeback and flag the error.
      S_MEM: if (cnt_q == CW'(TIMEOUT)) begin
        PC_ADVANCE = 1'b1;
        mem_err_d  = 1'b1;
        state_d    = S_FETCH;
      end else begin
        MEM_READ  = !d_store;
        MEM_WRITE = d_store;
        if (MEM_BUSYWAIT) cnt_d = cnt_q + CW'(1);
        else begin
          PC_ADVANCE = d_store;
          state_d    = d_store ? S_FETCH : S_WB;
        end
      end
      S_WB: begin
        WRITEENABLE = 1'b1;
        MUX_MEMDATA = 1'b1;
        PC_ADVANCE  = 1'b1;
        state_d     = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end
  assign MEM_ERR = mem_err_q;
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q   <= S_FETCH;
      op_q      <= '0;
      cnt_q     <= '0;
      mem_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      cnt_q     <= cnt_d;
      mem_err_q <= mem_err_d;
    end
  end
endmodule

// File: tb/tb_control_fsm.sv
// tb_control_fsm: per-cycle expected control vectors queued at drive time, compared after settling.
module tb_control_fsm;
  localparam logic [15:0] WE = 16'h0800, MI = 16'h0400, IM = 16'h0200, MD = 16'h0100;
  localparam logic [15:0] BR = 16'h0080, JP = 16'h0040, BN = 16'h0020, RD = 16'h0010;
  localparam logic [15:0] WR = 16'h0008, PC = 16'h0004, IL = 16'h0002, ER = 16'h0001;
  logic CLK = 1'b0;
  logic RESET = 1'b0;
  logic [31:0] INSTRUCTION = 32'h0;
  logic INSTR_VALID = 1'b0;
  logic MEM_BUSYWAIT = 1'b0;
  logic [3:0] ALUOP;
  logic WRITEENABLE, MUX_MINUS, MUX_IMMEDIATE, MUX_MEMDATA, BRANCH, JUMP, B_NOTEQUAL;
  logic MEM_READ, MEM_WRITE, PC_ADVANCE, ILLEGAL, MEM_ERR;
  logic [15:0] obs, want;
  logic [15:0] exp_q [$];
  int checks = 0;
  int failures = 0;
  always #5 CLK = ~CLK;
  control_fsm #(.INSTR_W(32), .OPCODE_W(8), .ALUOP_W(4), .TIMEOUT(4)) dut (
    .CLK(CLK), .RESET(RESET), .INSTRUCTION(INSTRUCTION), .INSTR_VALID(INSTR_VALID),
    .MEM_BUSYWAIT(MEM_BUSYWAIT), .ALUOP(ALUOP), .WRITEENABLE(WRITEENABLE),
    .MUX_MINUS(MUX_MINUS), .MUX_IMMEDIATE(MUX_IMMEDIATE), .MUX_MEMDATA(MUX_MEMDATA),
    .BRANCH(BRANCH), .JUMP(JUMP), .B_NOTEQUAL(B_NOTEQUAL), .MEM_READ(MEM_READ),
    .MEM_WRITE(MEM_WRITE), .PC_ADVANCE(PC_ADVANCE), .ILLEGAL(ILLEGAL), .MEM_ERR(MEM_ERR)
  );
  assign obs = {ALUOP, WRITEENABLE, MUX_MINUS, MUX_IMMEDIATE, MUX_MEMDATA, BRANCH, JUMP,
                B_NOTEQUAL, MEM_READ, MEM_WRITE, PC_ADVANCE, ILLEGAL, MEM_ERR};
  function automatic logic [15:0] alu(input int n);
    return 16'(n) << 12;
  endfunction
  task automatic drive(input logic v, input logic [31:0] ins, input logic b, input logic [15:0] e);
    @(negedge CLK);
    INSTR_VALID = v;
    INSTRUCTION = ins;
    MEM_BUSYWAIT = b;
    exp_q.push_back(e);
    #1;
  endtask
  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h02030105, 1'b1, 16'h0);
      want = exp_q.pop_front();
      checks++;
      if (obs !== want) begin
        failures++;
        $display("FAIL reset_hold[%0d]: got %h want %h", i, obs, want);
      end
    end
    @(negedge CLK);
    INSTR_VALID = 1'b0;
    MEM_BUSYWAIT = 1'b0;
    RESET = 1'b1;
  endtask
  task automatic test_back_to_back();
    logic [7:0] ops [13];
    logic [15:0] e [13];
    ops = '{8'h02, 8'h03, 8'h04, 8'h05, 8'h01, 8'h00, 8'h09, 8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h06, 8'h08};
    e = '{alu(1)|WE|PC, alu(1)|MI|WE|PC, alu(2)|WE|PC, alu(3)|WE|PC, WE|PC, IM|WE|PC,
          alu(4)|IM|WE|PC, alu(5)|IM|WE|PC, alu(6)|IM|WE|PC, alu(7)|IM|WE|PC,
          alu(8)|WE|PC, JP|PC, alu(1)|MI|BN|PC};
    for (int i = 0; i < 13; i++) begin
      drive(1'b1, {ops[i], 24'h030105}, 1'b0, 16'h0);
      want = exp_q.pop_front();
      checks++;
      if (obs !== want) begin
        failures++;
        $display("FAIL fetch op%h: got %h want %h", ops[i], obs, want);
      end
      drive(1'b1, 32'hFF000000, 1'b0, e[i]);
      want = exp_q.pop_front();
      checks++;
      if (obs !== want) begin
        failures++;
        $display("FAIL exec op%h: got %h want %h", ops[i], obs, want);
      end
    end
    drive(1'b0, 32'h0, 1'b0, 16'h0);
    want = exp_q.pop_front();
    checks++;
    if (obs !== want) begin
      failures++;
      $display("FAIL back_to_back_idle: got %h want %h", obs, want);
    end
  endtask
  task automatic test_single(input logic [7:0] op, input logic [15:0] e_exec);
    logic [15:0] e [3];
    e = '{16'h0, e_exec, 16'h0};
    for (int i = 0; i < 3; i++) begin
      drive(i == 0, {op, 24'h000000}, 1'b0, e[i]);
      want = exp_q.pop_front();
      checks++;
      if (obs !== want) begin
        failures++;
        $display("FAIL single op%h cyc%0d: got %h want %h", op, i, obs, want);
      end
    end
  endtask
  task automatic test_load();
    logic [15:0] e [8];
    logic [7:0] busy = 8'b0001_1100;
    e = '{16'h0, 16'h0, RD, RD, RD, RD, WE|MD|PC, 16'h0};
    for (int i = 0; i < 8; i++) begin
      drive(i == 0, 32'h0E000000, busy[i], e[i]);
      want = exp_q.pop_front();
      checks++;
      if (obs !== want) begin
        failures++;
        $display("FAIL load cyc%0d: got %h want %h", i, obs, want);
      end
    end
  endtask
  task automatic test_store();
    logic [15:0] e [4];
    e = '{16'h0, 16'h0, WR|PC, 16'h0};
    for (int i = 0; i < 4; i++) begin
      drive(i == 0, 32'h10000000, 1'b0, e[i]);
      want = exp_q.pop_front();
      checks++;
      if (obs !== want) begin
        failures++;
        $display("FAIL store cyc%0d: got %h want %h", i, obs, want);
      end
    end
  endtask
  task automatic test_timeout();
    logic [15:0] e [9];
    e = '{16'h0, IM, WR, WR, WR, WR, PC, ER, ER};
    for (int i = 0; i < 9; i++) begin
      drive(i == 0, 32'h11000000, 1'b1, e[i]);
      want = exp_q.pop_front();
      checks++;
      if (obs !== want) begin
        failures++;
        $display("FAIL timeout cyc%0d: got %h want %h", i, obs, want);
      end
    end
  endtask
  task automatic test_reset_mid_mem();
    logic [15:0] e [3];
    e = '{ER, IM|ER, RD|ER};
    for (int i = 0; i < 3; i++) begin
      drive(i == 0, 32'h0F000000, 1'b1, e[i]);
      want = exp_q.pop_front();
      checks++;
      if (obs !== want) begin
        failures++;
        $display("FAIL midmem cyc%0d: got %h want %h", i, obs, want);
      end
    end
    RESET = 1'b0;
    exp_q.push_back(16'h0);
    #1;
    want = exp_q.pop_front();
    checks++;
    if (obs !== want) begin
      failures++;
      $display("FAIL midmem_async_drop: got %h want %h", obs, want);
    end
    drive(1'b0, 32'h0, 1'b1, 16'h0);
    want = exp_q.pop_front();
    checks++;
    if (obs !== want) begin
      failures++;
      $display("FAIL midmem_in_reset: got %h want %h", obs, want);
    end
    @(negedge CLK);
    MEM_BUSYWAIT = 1'b0;
    RESET = 1'b1;
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 32'h0, 1'b0, 16'h0);
      want = exp_q.pop_front();
      checks++;
      if (obs !== want) begin
        failures++;
        $display("FAIL midmem_after[%0d]: got %h want %h", i, obs, want);
      end
    end
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end
  initial begin
    test_reset();
    test_back_to_back();
    test_single(8'h02, alu(1)|WE|PC);
    test_single(8'h07, alu(1)|MI|BR|PC);
    test_single(8'hFF, IL|PC);
    test_single(8'h12, IL|PC);
    test_load();
    test_store();
    test_timeout();
    test_reset_mid_mem();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/control_fsm.md
CONTROL_FSM -- requirements
Module: control_fsm

Interface
REQ-001 SHALL have parameter INSTR_W, default 32, instruction width.
REQ-002 SHALL have parameter OPCODE_W, default 8, opcode width; opcode = INSTRUCTION[INSTR_W-1 -: OPCODE_W].
REQ-003 SHALL have parameter ALUOP_W, default 4, ALU operation select width.
REQ-004 SHALL have parameter TIMEOUT, default 16, maximum MEM wait cycles, at least 1.
REQ-005 SHALL have port CLK, input, 1 bit: the single clock, rising-edge.
REQ-006 SHALL have port RESET, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port INSTRUCTION, input, INSTR_W bits: fetched instruction.
REQ-008 SHALL have port INSTR_VALID, input, 1 bit: INSTRUCTION is valid this cycle.
REQ-009 SHALL have port MEM_BUSYWAIT, input, 1 bit: data memory not yet done.
REQ-010 SHALL have port ALUOP, output, ALUOP_W bits: ALU function.
REQ-011 SHALL have outputs WRITEENABLE, MUX_MINUS, MUX_IMMEDIATE, MUX_MEMDATA, BRANCH, JUMP, B_NOTEQUAL, 1 bit each: datapath controls.
REQ-012 SHALL have outputs MEM_READ and MEM_WRITE, 1 bit each: data memory requests.
REQ-013 SHALL have output PC_ADVANCE, 1 bit: one-cycle retire pulse; the PC updates only when it is high.
REQ-014 SHALL have outputs ILLEGAL (1-cycle pulse) and MEM_ERR (sticky), 1 bit each.

Function
REQ-015 SHALL have states FETCH, EXEC, MEM, WB, with all outputs decoded from the state and the registered opcode.
REQ-016 In FETCH, on a rising edge with INSTR_VALID=1, SHALL capture the opcode and go to EXEC; otherwise it SHALL stay in FETCH with all outputs 0.
REQ-017 SHALL decode in EXEC: add 0x02 (ALUOP 1), sub 0x03 (ALUOP 1, MUX_MINUS), and 0x04 (ALUOP 2), or 0x05 (ALUOP 3), mov 0x01 (ALUOP 0), loadi 0x00 (ALUOP 0, MUX_IMMEDIATE).
REQ-018 SHALL further decode in EXEC: srl 0x09 (4), sll 0x0A (5), ror 0x0B (6), sra 0x0C (7), all with MUX_IMMEDIATE; mul 0x0D (ALUOP 8).
REQ-019 For every opcode in REQ-017 and REQ-018, SHALL assert WRITEENABLE and PC_ADVANCE in EXEC and then return to FETCH (latency one EXEC cycle).
REQ-020 For beq 0x07 and bne 0x08, SHALL assert ALUOP 1 and MUX_MINUS with BRANCH or B_NOTEQUAL respectively, plus PC_ADVANCE, in EXEC; WRITEENABLE SHALL be 0.
REQ-021 For j 0x06, SHALL assert JUMP and PC_ADVANCE in EXEC.
REQ-022 For lwd 0x0E, lwi 0x0F, swd 0x10 and swi 0x11, SHALL assert ALUOP 0 in EXEC (with MUX_IMMEDIATE for lwi/swi) and then go to MEM.
REQ-023 In MEM, SHALL hold MEM_READ (loads) or MEM_WRITE (stores) high while MEM_BUSYWAIT=1.
REQ-024 On a MEM cycle with MEM_BUSYWAIT=0: a load SHALL go to WB; a store SHALL pulse PC_ADVANCE and go to FETCH.
REQ-025 In WB, SHALL assert WRITEENABLE, MUX_MEMDATA and PC_ADVANCE for one cycle, then go to FETCH.
REQ-026 SHALL have a wait counter of width clog2(TIMEOUT+1) that clears on entry to MEM and counts busy cycles.
REQ-027 When the wait counter reaches TIMEOUT, SHALL deassert the memory request, set MEM_ERR, pulse PC_ADVANCE, skip WB, and go to FETCH.
REQ-028 For an unknown opcode in EXEC, SHALL pulse ILLEGAL and PC_ADVANCE with every enable at 0.
REQ-029 INSTR_VALID SHALL be ignored outside FETCH; PC_ADVANCE SHALL never be high in two consecutive cycles.

Reset
REQ-030 While RESET=0, SHALL go to FETCH asynchronously and drive every output to 0, including MEM_ERR.
REQ-031 A reset mid-MEM SHALL drop MEM_READ/MEM_WRITE immediately, with no writeback or retire.
REQ-032 SHALL leave reset on the first rising CLK after RESET=1.

Structure
REQ-033 The opcode constants, ALUOP codes and state enum SHALL live in shared package cpu_pkg.
REQ-034 The pure opcode-to-control decode SHALL be sub-module ctrl_decode; the state machine, counter and MEM_ERR SHALL live in control_fsm.

Verification
REQ-035 Reset low then high, INSTRUCTION=0x02030105 valid: EXEC has ALUOP=1, WRITEENABLE=1, PC_ADVANCE=1; the next cycle is FETCH.
REQ-036 Opcode 0x07: the EXEC cycle has BRANCH=1, MUX_MINUS=1, WRITEENABLE=0.
REQ-037 Opcode 0x0E with BUSYWAIT high for 3 cycles: MEM_READ is high 4 cycles; WB then has WRITEENABLE=1, MUX_MEMDATA=1, PC_ADVANCE=1.
REQ-038 Opcode 0x11 with BUSYWAIT stuck high and TIMEOUT=4: MEM_WRITE drops after 4 busy cycles, MEM_ERR=1, PC_ADVANCE pulses once.
REQ-039 Opcode 0xFF: ILLEGAL=1 and PC_ADVANCE=1 in one cycle, with all enables 0.
REQ-040 RESET=0 during MEM of opcode 0x0F: MEM_READ falls without waiting for CLK, and no WB occurs.
